// File: rtl/vedic_mult_seq.sv
// Sequential Vedic multiplier: retires one 4-bit multiplier digit per cycle through a
// WIDTH x 4 Vedic partial-product array. Define VEDIC_MULT_SIGNED_EN for two's-complement operands.

module ripple_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o
);
  logic [W-1:0] c_s;

  assign c_s[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s_o[i] = a_i[i] ^ b_i[i] ^ c_s[i];
    // The carry out of the top bit is dropped; callers size W so the sum never overflows.
    if (i < W - 1) begin : g_carry
      assign c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
  end
endmodule

module vedic2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic t1_s, t2_s, t3_s, c1_s;

  assign t1_s   = a_i[1] & b_i[0];
  assign t2_s   = a_i[0] & b_i[1];
  assign t3_s   = a_i[1] & b_i[1];
  assign c1_s   = t1_s & t2_s;
  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = t1_s ^ t2_s;
  assign p_o[2] = t3_s ^ c1_s;
  assign p_o[3] = t3_s & c1_s;
endmodule

module vedic4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] m0_s, m1_s, m2_s, m3_s;
  logic [4:0] s1_s;
  logic [5:0] s2_s;

  vedic2x2 u_m0 (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(m0_s));
  vedic2x2 u_m1 (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(m1_s));
  vedic2x2 u_m2 (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(m2_s));
  vedic2x2 u_m3 (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(m3_s));

  // Cross terms summed first, then folded into the high term aligned two bits up.
  ripple_add #(.W(5)) u_cross (.a_i({1'b0, m1_s}), .b_i({1'b0, m2_s}), .s_o(s1_s));
  ripple_add #(.W(6)) u_high  (.a_i({m3_s, m0_s[3:2]}), .b_i({1'b0, s1_s}), .s_o(s2_s));

  assign p_o = {s2_s, m0_s[1:0]};
endmodule

module vedic_wx4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [3:0]       d_i,
  output logic [WIDTH+3:0] p_o
);
  localparam int NDIG = WIDTH / 4;

  logic [7:0]       dp_s    [NDIG];
  logic [WIDTH+3:0] chain_s [NDIG];

  for (genvar j = 0; j < NDIG; j++) begin : g_dig
    vedic4x4 u_v (.a_i(a_i[4*j+3:4*j]), .b_i(d_i), .p_o(dp_s[j]));
    if (j == 0) begin : g_first
      assign chain_s[j] = (WIDTH+4)'(dp_s[j]);
    end else begin : g_acc
      ripple_add #(.W(WIDTH+4)) u_add (
        .a_i(chain_s[j-1]),
        .b_i((WIDTH+4)'(dp_s[j]) << (4*j)),
        .s_o(chain_s[j])
      );
    end
  end

  assign p_o = chain_s[NDIG-1];
endmodule

module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);
  localparam int NDIG = WIDTH / 4;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, add_s;
  logic [KW-1:0]      k_q, k_d;
  logic [3:0]         digit_s;
  logic [WIDTH+3:0]   pp_s;
`ifdef VEDIC_MULT_SIGNED_EN
  logic               sign_q, sign_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // The most-negative value maps to its own bit pattern, which is the correct unsigned magnitude.
    mag = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  assign digit_s = 4'(b_q >> {k_q, 2'b00});

  vedic_wx4 #(.WIDTH(WIDTH)) u_array (.a_i(a_q), .d_i(digit_s), .p_o(pp_s));

  assign add_s = acc_q + ((2*WIDTH)'(pp_s) << {k_q, 2'b00});

  // State, operand and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
`ifdef VEDIC_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef VEDIC_MULT_SIGNED_EN
          a_d    = mag(a);
          b_d    = mag(b);
          sign_d = a[WIDTH-1] ^ b[WIDTH-1];
`else
          a_d    = a;
          b_d    = b;
`endif
          acc_d   = '0;
          k_d     = '0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = add_s;
        if (k_q == KW'(NDIG - 1)) begin
`ifdef VEDIC_MULT_SIGNED_EN
          acc_d = sign_q ? (~add_s + (2*WIDTH)'(1)) : add_s;
`endif
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign prod      = acc_q;
endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH=8 and WIDTH=16; expectations follow VEDIC_MULT_SIGNED_EN.

module tb_vedic_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, ir8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, ov16, or16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  int          nchk = 0;
  int          nerr = 0;

`ifdef VEDIC_MULT_SIGNED_EN
  localparam logic [15:0] E_FFFF = 16'h0001;
  localparam logic [15:0] E_8080 = 16'h4000;
  localparam logic [15:0] E_FF02 = 16'hFFFE;
  localparam logic [15:0] E_7F81 = 16'hC0FF;
  localparam logic [31:0] E_W16  = 32'hFA034FA4;
`else
  localparam logic [15:0] E_FFFF = 16'hFE01;
  localparam logic [15:0] E_8080 = 16'h4000;
  localparam logic [15:0] E_FF02 = 16'h01FE;
  localparam logic [15:0] E_7F81 = 16'h3FFF;
  localparam logic [31:0] E_W16  = 32'h0C374FA4;
`endif

  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(bz8)
  );

  vedic_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .prod(p16), .busy(bz16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 transaction: operands scrambled and in_valid pulsed while busy, new operands offered during DONE.
  task automatic mul8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    check({tag, "_rdy"}, ir8, 1);
    a8 = av; b8 = bv; iv8 = 1'b1; or8 = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check({tag, "_busy"}, {bz8, ir8}, 2'b10);
        a8 = ~av; b8 = ~bv;
      end else begin
        iv8 = 1'b0;
      end
    end while (!ov8 && n < 20);
    check({tag, "_lat"}, n, 3);
    check({tag, "_prod"}, p8, exp);
    iv8 = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rel"}, {ov8, ir8, bz8}, 3'b010);
    iv8 = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    @(posedge clk); #1;
    check("rst8", {ir8, ov8, bz8, p8}, {3'b100, 16'h0000});
    check("rst16", {ir16, ov16, bz16, p16}, {3'b100, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    mul8(8'hFF, 8'hFF, E_FFFF, "ff_ff");
    mul8(8'h0D, 8'h00, 16'h0000, "zero_b");
    mul8(8'h12, 8'h34, 16'h03A8, "isolate");

    // Reset in the middle of a multiplication.
    a8 = 8'h55; b8 = 8'h66; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", bz8, 1);
    rst_n = 1'b0;
    #1;
    check("midrst", {ov8, ir8, bz8, p8}, {3'b010, 16'h0000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    mul8(8'h07, 8'h09, 16'h003F, "after_rst");

    mul8(8'h80, 8'h80, E_8080, "s_8080");
    mul8(8'hFF, 8'h02, E_FF02, "s_ff02");
    mul8(8'h7F, 8'h81, E_7F81, "s_7f81");

    // WIDTH=16 with back-pressure.
    n = 0;
    a16 = 16'h1234; b16 = 16'hABCD; iv16 = 1'b1; or16 = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      iv16 = 1'b0;
      a16 = 16'hFFFF; b16 = 16'hFFFF;
    end while (!ov16 && n < 30);
    check("w16_lat", n, 5);
    check("w16_prod", p16, E_W16);
    for (int i = 0; i < 5; i++) begin
      iv16 = 1'b1;
      @(posedge clk); #1;
      check("w16_hold", {ov16, bz16, ir16, p16}, {3'b100, E_W16});
    end
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    check("w16_rel", {ov16, ir16}, 2'b01);
    or16 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
